// File: rtl/ibex_dmem_responder.sv
// Ibex data-bus responder for the 256x32 dmem macro (active-low CEN/WEN, 1-cycle read).
// Partial writes are done as read-modify-write since the macro has only a word-wide WEN.
module ibex_dmem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_cen_o,
  output logic        mem_wen_o,
  output logic [7:0]  mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  // Handshake: a request is accepted in the cycle data_req_i && data_gnt_o; exactly one
  // data_rvalid_o follows, and no new grant is issued until that response has been given.
  typedef enum logic [1:0] {IDLE, RD, RMW, RESP} state_e;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        in_range;
  logic [31:0] merged;
  logic        unused_addr_lsb;

  assign in_range        = (data_addr_i[31:10] == BASE_ADDR[31:10]);
  assign unused_addr_lsb = ^data_addr_i[1:0];

  always_comb begin
    merged = mem_rdata_i;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      addr_q  <= 8'h00;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Everything is gated by rst_ni so outputs drop to reset values the moment reset asserts,
  // including a pending RMW macro write.
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_rdata_o  = 32'h0;
    data_err_o    = 1'b0;
    mem_cen_o     = 1'b1;
    mem_wen_o     = 1'b1;
    mem_addr_o    = 8'h00;
    mem_wdata_o   = 32'h0;
    if (rst_ni) begin
      unique case (state_q)
        IDLE: begin
          if (data_req_i) begin
            data_gnt_o = 1'b1;
            err_d      = 1'b0;
            state_d    = RESP;
            if (!in_range) begin
              err_d = 1'b1;
            end else if (!data_we_i) begin
              mem_cen_o  = 1'b0;
              mem_addr_o = data_addr_i[9:2];
              state_d    = RD;
            end else if (data_be_i == 4'hF) begin
              mem_cen_o   = 1'b0;
              mem_wen_o   = 1'b0;
              mem_addr_o  = data_addr_i[9:2];
              mem_wdata_o = data_wdata_i;
            end else if (data_be_i != 4'h0) begin
              mem_cen_o  = 1'b0;
              mem_addr_o = data_addr_i[9:2];
              addr_d     = data_addr_i[9:2];
              be_d       = data_be_i;
              wdata_d    = data_wdata_i;
              state_d    = RMW;
            end
          end
        end
        RD: begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = mem_rdata_i;
          state_d       = IDLE;
        end
        RMW: begin
          mem_cen_o   = 1'b0;
          mem_wen_o   = 1'b0;
          mem_addr_o  = addr_q;
          mem_wdata_o = merged;
          state_d     = RESP;
        end
        RESP: begin
          data_rvalid_o = 1'b1;
          data_err_o    = err_q;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_dmem_responder.sv
// Bench for ibex_dmem_responder: directed protocol/reset steps, then random traffic
// checked against a word-array reference of the data memory.
module tb_ibex_dmem_responder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_cen_o;
  logic        mem_wen_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  int exp_wr = 0;

  logic [31:0] ref_mem [256] = '{default: '0};
  logic [32:0] exp_q [$];

  // ---------------- clock / macro model ----------------
  always #5 clk = ~clk;

  logic [31:0] sram [256] = '{default: '0};
  logic [31:0] sram_q = '0;
  always @(posedge clk) begin
    if (!mem_cen_o) begin
      if (!mem_wen_o) begin
        sram[mem_addr_o] <= mem_wdata_o;
        n_wr             <= n_wr + 1;
      end else begin
        sram_q <= sram[mem_addr_o];
      end
    end
  end
  assign mem_rdata_i = sram_q;

  ibex_dmem_responder #(.BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    32'(data_gnt_o),    32'd0);
    check({tag, "_rvalid"}, 32'(data_rvalid_o), 32'd0);
    check({tag, "_rdata"},  data_rdata_o,       32'h0);
    check({tag, "_err"},    32'(data_err_o),    32'd0);
    check({tag, "_cen"},    32'(mem_cen_o),     32'd1);
    check({tag, "_wen"},    32'(mem_wen_o),     32'd1);
    check({tag, "_maddr"},  32'(mem_addr_o),    32'd0);
    check({tag, "_mwdata"}, mem_wdata_o,        32'h0);
  endtask

  // ---------------- driver ----------------
  // Drives one request, checks every cycle up to and including its response.
  task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit keep,
                     output int waited, output logic [31:0] rdata_got);
    logic        in_rng, access, part;
    logic [7:0]  widx;
    logic [31:0] merged;
    logic [32:0] exp;
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    rdata_got    = '0;
    #1;
    waited = 0;
    while (data_gnt_o !== 1'b1 && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    check("gnt_T", 32'(data_gnt_o), 32'd1);
    if (data_gnt_o !== 1'b1) begin
      data_req_i = 1'b0;
      return;
    end
    widx   = addr[9:2];
    in_rng = (addr[31:10] == BASE[31:10]);
    access = in_rng && !(we && be == 4'h0);
    part   = in_rng && we && be != 4'h0 && be != 4'hF;
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : ref_mem[widx][8*b +: 8];
    exp_q.push_back({!in_rng, (in_rng && !we) ? ref_mem[widx] : 32'h0});
    if (in_rng && we && be != 4'h0) exp_wr++;

    check("cen_T", 32'(mem_cen_o), access ? 32'd0 : 32'd1);
    check("wen_T", 32'(mem_wen_o), (access && we && !part) ? 32'd0 : 32'd1);
    if (access) check("maddr_T", 32'(mem_addr_o), 32'(widx));
    if (access && we && !part) check("mwdata_T", mem_wdata_o, wdata);

    @(posedge clk); #1;
    if (!keep) data_req_i = 1'b0;
    @(negedge clk); #1;
    if (part) begin
      check("rmw_cen",    32'(mem_cen_o),     32'd0);
      check("rmw_wen",    32'(mem_wen_o),     32'd0);
      check("rmw_maddr",  32'(mem_addr_o),    32'(widx));
      check("rmw_mwdata", mem_wdata_o,        merged);
      check("rmw_rvalid", 32'(data_rvalid_o), 32'd0);
      check("rmw_gnt",    32'(data_gnt_o),    32'd0);
      @(negedge clk); #1;
    end
    check("rsp_rvalid", 32'(data_rvalid_o), 32'd1);
    check("rsp_gnt",    32'(data_gnt_o),    32'd0);
    check("rsp_cen",    32'(mem_cen_o),     32'd1);
    check("rsp_wen",    32'(mem_wen_o),     32'd1);
    check("rsp_maddr",  32'(mem_addr_o),    32'd0);
    check("rsp_mwdata", mem_wdata_o,        32'h0);
    exp = exp_q.pop_front();
    check("rsp_err",   32'(data_err_o), 32'(exp[32]));
    check("rsp_rdata", data_rdata_o,    exp[31:0]);
    rdata_got = data_rdata_o;
    if (in_rng && we) ref_mem[widx] = merged;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          w, w2;
    logic [31:0] r;
    logic [31:0] a;
    logic        rwe;
    logic [3:0]  rbe;
    bit          rkeep;

    rst_ni = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    repeat (2) @(negedge clk);
    data_req_i = 1'b1; data_be_i = 4'hF;
    #1;
    check_reset_outputs("inreset");

    // Release with a read of 0x0 pending; then reset it asynchronously during its response.
    @(negedge clk); rst_ni = 1'b1; #1;
    check("first_gnt", 32'(data_gnt_o), 32'd1);
    check("first_cen", 32'(mem_cen_o),  32'd0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("rd_rvalid_pre", 32'(data_rvalid_o), 32'd1);
    rst_ni = 1'b0; #1;
    check_reset_outputs("async");
    data_req_i = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    #1;
    txn(1'b0, 4'hF, 32'h0, 32'h0, 1'b0, w, r);
    check("post_rst_wait", 32'(w), 32'd0);

    // Full write then read back.
    txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, w, r);
    txn(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, w, r);
    check("full_rd", r, 32'hDEADBEEF);

    // Partial write (be=0101) then read back.
    txn(1'b1, 4'b0101, 32'h10, 32'h11223344, 1'b0, w, r);
    txn(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, w, r);
    check("part_rd", r, 32'hDE22BE44);

    // Out-of-range read and be=0 write.
    txn(1'b0, 4'hF, 32'h0000_0400, 32'h0, 1'b0, w, r);
    txn(1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 1'b0, w, r);
    txn(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, w, r);
    check("be0_rd", r, 32'hDE22BE44);

    // Back-to-back reads with req held high.
    txn(1'b0, 4'hF, 32'h0, 32'h0, 1'b1, w, r);
    txn(1'b0, 4'hF, 32'h4, 32'h0, 1'b0, w2, r);
    check("b2b_wait", 32'(w2), 32'd1);

    // Reset during the RMW cycle aborts the write and the response.
    txn(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 1'b0, w, r);
    @(negedge clk);
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
    data_addr_i = 32'h20; data_wdata_i = 32'h55667788;
    #1;
    check("abort_gnt", 32'(data_gnt_o), 32'd1);
    check("abort_wen", 32'(mem_wen_o),  32'd1);
    @(posedge clk); #1;
    data_req_i = 1'b0;
    @(negedge clk); #1;
    check("abort_rmw_wen", 32'(mem_wen_o), 32'd0);
    rst_ni = 1'b0; #1;
    check_reset_outputs("abort");
    @(negedge clk); #1;
    check("abort_no_rvalid", 32'(data_rvalid_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    txn(1'b0, 4'hF, 32'h20, 32'h0, 1'b0, w, r);
    check("abort_unchanged", r, 32'hCAFEF00D);
    check("abort_gnt_idle", 32'(w), 32'd0);

    // Random traffic over a small window so words are reused.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0400;
      else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      rwe   = 1'($urandom_range(0, 1));
      rbe   = 4'($urandom_range(0, 15));
      rkeep = (i != 199) && ($urandom_range(0, 1) == 1);
      txn(rwe, rbe, a, $urandom, rkeep, w, r);
    end

    @(negedge clk);
    check("macro_writes", 32'(n_wr), 32'(exp_wr));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
